// File: rtl/fir_coef_sequencer.sv
// Coefficient load sequencer for the FIR core: streams N coefficients into
// the core, waits a settle interval, then opens the sample path.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   start            pulse: (re)load all N coefficients (IDLE or RUN only)
//   coef_in/valid    coefficient stream in; coef_ready is high in LOAD
//   cload/caddr/cin  registered coefficient write strobe to the core
//   samp_valid_in    upstream sample stream (samp_in)
//   fir_valid_in     registered sample stream to the core (fir_din)
//   busy             LOAD or SETTLE
//   loaded           full coefficient set present, sample path open
//   drop_err         sticky: sample arrived while the path was closed
//   tap_cnt          coefficients accepted in the current load
module fir_coef_sequencer #(
  parameter int M          = 16,
  parameter int N          = 64,
  parameter int AW         = 6,
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [M-1:0]  coef_in,
  input  logic          coef_valid,
  output logic          coef_ready,
  output logic          cload,
  output logic [AW-1:0] caddr,
  output logic [M-1:0]  cin,
  input  logic          samp_valid_in,
  input  logic [M-1:0]  samp_in,
  output logic          fir_valid_in,
  output logic [M-1:0]  fir_din,
  output logic          busy,
  output logic          loaded,
  output logic          drop_err,
  output logic [AW:0]   tap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN
  } state_t;

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [AW:0]   LAST  = (AW + 1)'(N - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);

  state_t        state;
  logic [SW-1:0] scnt;
  logic          hs;
  logic          run;
  logic          restart;

  assign coef_ready = (state == LOAD);
  assign busy       = (state == LOAD) | (state == SETTLE);
  assign run        = (state == RUN);
  assign hs         = coef_valid & coef_ready;
  // start is only honoured when no load is in flight
  assign restart    = start & ((state == IDLE) | run);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      scnt         <= '0;
      cload        <= 1'b0;
      caddr        <= '0;
      cin          <= '0;
      fir_valid_in <= 1'b0;
      fir_din      <= '0;
      loaded       <= 1'b0;
      drop_err     <= 1'b0;
      tap_cnt      <= '0;
    end else begin
      cload <= hs;
      if (hs) begin
        caddr   <= tap_cnt[AW-1:0];
        cin     <= coef_in;
        tap_cnt <= tap_cnt + 1'b1;
      end

      fir_valid_in <= samp_valid_in & run;
      if (samp_valid_in & run)
        fir_din <= samp_in;

      // a drop in the same cycle as the clearing start must win
      if (restart)
        drop_err <= 1'b0;
      if (samp_valid_in & ~run)
        drop_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            tap_cnt <= '0;
          end
        end
        LOAD: begin
          if (hs && tap_cnt == LAST) begin
            state <= SETTLE;
            scnt  <= '0;
          end
        end
        SETTLE: begin
          // first SETTLE cycle is the one carrying the last cload
          if (scnt == SLAST) begin
            state  <= RUN;
            loaded <= 1'b1;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            state   <= LOAD;
            loaded  <= 1'b0;
            tap_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Self-checking bench for fir_coef_sequencer: directed sequences, a vector
// table for the sample path, and random traffic against a reference model.
module tb_fir_coef_sequencer;

  localparam int M  = 16;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [M-1:0]  coef_in;
  logic          coef_valid;
  logic          coef_ready;
  logic          cload;
  logic [AW-1:0] caddr;
  logic [M-1:0]  cin;
  logic          samp_valid_in;
  logic [M-1:0]  samp_in;
  logic          fir_valid_in;
  logic [M-1:0]  fir_din;
  logic          busy;
  logic          loaded;
  logic          drop_err;
  logic [AW:0]   tap_cnt;

  fir_coef_sequencer #(.M(M), .N(N), .AW(AW), .SETTLE_CYC(S)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .cload(cload), .caddr(caddr), .cin(cin),
    .samp_valid_in(samp_valid_in), .samp_in(samp_in),
    .fir_valid_in(fir_valid_in), .fir_din(fir_din),
    .busy(busy), .loaded(loaded), .drop_err(drop_err), .tap_cnt(tap_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: accepted-count / settle-countdown / open-path view
  bit       m_ld;
  int       m_acc;
  int       m_settle;
  bit       m_open;
  bit       m_drop;
  bit       m_cload;
  int       m_caddr;
  bit [M-1:0] m_cin;
  bit       m_fv;
  bit [M-1:0] m_fd;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hs, was_open, idle, dropped;
    if (!rstn) begin
      m_ld = 0; m_acc = 0; m_settle = 0; m_open = 0; m_drop = 0;
      m_cload = 0; m_caddr = 0; m_cin = '0; m_fv = 0; m_fd = '0;
      return;
    end
    was_open = m_open;
    idle     = !m_ld && m_settle == 0 && !m_open;
    hs       = coef_valid && m_ld;
    dropped  = samp_valid_in && !was_open;
    m_fv     = samp_valid_in && was_open;
    if (m_fv) m_fd = samp_in;
    m_cload = hs;
    if (hs) begin
      m_caddr = m_acc;
      m_cin   = coef_in;
      m_acc++;
      if (m_acc == N) begin
        m_ld     = 0;
        m_settle = S;
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) m_open = 1;
    end
    if (start && (idle || was_open)) begin
      m_ld   = 1;
      m_acc  = 0;
      m_open = 0;
      m_drop = 0;
    end
    if (dropped) m_drop = 1;
  endtask

  task automatic compare_all();
    check("coef_ready", 32'(coef_ready), 32'(m_ld));
    check("busy", 32'(busy), 32'(m_ld || m_settle > 0));
    check("cload", 32'(cload), 32'(m_cload));
    check("caddr", 32'(caddr), 32'(m_caddr));
    check("cin", 32'(cin), 32'(m_cin));
    check("fir_valid_in", 32'(fir_valid_in), 32'(m_fv));
    check("fir_din", 32'(fir_din), 32'(m_fd));
    check("loaded", 32'(loaded), 32'(m_open));
    check("drop_err", 32'(drop_err), 32'(m_drop));
    check("tap_cnt", 32'(tap_cnt), 32'(m_acc));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; coef_valid = 0; coef_in = '0;
    samp_valid_in = 0; samp_in = '0;
  endtask

  // full load; seq_data drives coef k as k+1, toggle gaps every other cycle
  task automatic do_load(input bit seq_data, input bit toggle,
                         input int restart_at, input int samp_cycles);
    int n;
    int k;
    n = 0;
    k = 0;
    start = 1;
    cyc();
    start = 0;
    while (n < N && k < 1000) begin
      coef_valid    = toggle ? (k % 2 == 0) : 1'b1;
      coef_in       = seq_data ? M'(n + 1) : M'($urandom);
      samp_valid_in = (k < samp_cycles);
      samp_in       = M'($urandom);
      start         = (k == restart_at);
      cyc();
      check("load_cload", 32'(cload), 32'(coef_valid));
      if (coef_valid) begin
        check("load_caddr", 32'(caddr), 32'(n));
        if (seq_data) check("load_cin", 32'(cin), 32'(n + 1));
        n++;
      end
      k++;
    end
    if (k >= 1000) check("load_timeout", 32'(n), 32'(N));
    idle_inputs();
  endtask

  task automatic wait_loaded();
    int k;
    k = 0;
    while (!loaded && k < 20) begin
      cyc();
      k++;
    end
    check("wait_loaded", 32'(loaded), 32'd1);
  endtask

  typedef struct {
    bit       sv;
    bit [M-1:0] sd;
    bit       exp_fv;
    bit [M-1:0] exp_fd;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, 16'h1234, 1'b1, 16'h1234};
    vt[1] = '{1'b1, 16'h8000, 1'b1, 16'h8000};
    vt[2] = '{1'b1, 16'h7FFF, 1'b1, 16'h7FFF};
    vt[3] = '{1'b0, 16'h5555, 1'b0, 16'h7FFF};
    vt[4] = '{1'b1, 16'h0001, 1'b1, 16'h0001};
    vt[5] = '{1'b0, 16'hFFFF, 1'b0, 16'h0001};

    idle_inputs();
    rstn = 0;
    cyc();
    cyc();
    check("rst_tap_cnt", 32'(tap_cnt), 32'd0);
    check("rst_coef_ready", 32'(coef_ready), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    rstn = 1;
    coef_valid = 1;
    cyc();
    check("idle_ignores_coef", 32'(cload), 32'd0);
    idle_inputs();

    // back-to-back load of 1..64
    do_load(1'b1, 1'b0, -1, 0);
    check("tap_cnt_full", 32'(tap_cnt), 32'(N));
    check("ready_low_after_last", 32'(coef_ready), 32'd0);
    cyc();
    check("settle_loaded_0", 32'(loaded), 32'd0);
    cyc();
    check("loaded_after_settle", 32'(loaded), 32'd1);
    check("busy_in_run", 32'(busy), 32'd0);

    // sample path vectors
    foreach (vt[i]) begin
      samp_valid_in = vt[i].sv;
      samp_in       = vt[i].sd;
      cyc();
      check("vec_fv", 32'(fir_valid_in), 32'(vt[i].exp_fv));
      check("vec_fd", 32'(fir_din), 32'(vt[i].exp_fd));
      check("vec_drop", 32'(drop_err), 32'd0);
    end
    idle_inputs();

    // restart from RUN with gapped stream and samples during load
    do_load(1'b0, 1'b1, -1, 4);
    check("drop_set", 32'(drop_err), 32'd1);
    wait_loaded();
    check("drop_sticky_run", 32'(drop_err), 32'd1);
    cyc();

    // start together with a sample: forwarded, drop cleared
    start = 1; samp_valid_in = 1; samp_in = 16'h00AA;
    cyc();
    check("start_fwd_fv", 32'(fir_valid_in), 32'd1);
    check("start_fwd_fd", 32'(fir_din), 32'h00AA);
    check("start_loaded_0", 32'(loaded), 32'd0);
    check("start_drop_clr", 32'(drop_err), 32'd0);
    idle_inputs();
    // the load task issues its own start; the DUT is already in LOAD so
    // that start and a later one mid-stream must both be ignored
    do_load(1'b0, 1'b0, 10, 0);
    wait_loaded();

    // reset after 30 coefficients
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 30; i++) begin
      coef_valid = 1;
      coef_in = M'($urandom);
      cyc();
    end
    rstn = 0;
    cyc();
    check("midrst_cload", 32'(cload), 32'd0);
    check("midrst_tap", 32'(tap_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rstn = 1;
    cyc();
    check("postrst_ignore", 32'(cload), 32'd0);
    check("postrst_ready", 32'(coef_ready), 32'd0);
    idle_inputs();
    do_load(1'b1, 1'b0, -1, 0);
    wait_loaded();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rstn          = ($urandom_range(0, 399) != 0);
      start         = ($urandom_range(0, 39) == 0);
      coef_valid    = $urandom_range(0, 1) == 1;
      coef_in       = M'($urandom);
      samp_valid_in = ($urandom_range(0, 9) < 3);
      samp_in       = M'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
